alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter N, default 4: ALU operand width; must match the attached alu instance.
REQ-002 SHALL have parameter SW, default $clog2(N)+1: shift-amount field width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when both valid and ready are high at a rising edge.
REQ-007 cmd_op  input  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 not, 101 shl, 110 shr, 111 mul.
REQ-008 cmd_a, cmd_b  input  N each  operands.
REQ-009 cmd_shamt  input  SW  shift amount; used only for 101/110.
REQ-010 alu_start  output  1  one-cycle start pulse to alu inp.
REQ-011 alu_op, alu_a, alu_b  output  3/N/N  registered operands to alu.
REQ-012 alu_y, alu_y_ext, alu_ovf  input  N/N/1  alu results.
REQ-013 rsp_valid  output  1  result available; rsp_ready  input  1  result consumed.
REQ-014 rsp_op, rsp_y, rsp_y_ext, rsp_ovf  output  3/N/N/1  captured result and its opcode.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 ops_done  output  8  count of completed response handshakes; wraps 255->0.

Function
REQ-017 FSM states SHALL be IDLE, START, RUN, DONE; cmd_ready = (state==IDLE); rsp_valid = (state==DONE).
REQ-018 IDLE: on cmd handshake, SHALL latch op/a/b into alu_op/alu_a/alu_b, compute wait count W, go to START.
REQ-019 W SHALL be N for opcodes 000-100 and 111; for 101/110, W = cmd_shamt clamped to range 1..N (0 -> 1, >N -> N).
REQ-020 START: alu_start SHALL be 1 for exactly this one cycle, then go to RUN with cycle counter loaded to W.
REQ-021 RUN: counter SHALL decrement each cycle; on the edge ending the W-th RUN cycle, SHALL capture alu_y, alu_y_ext, alu_ovf, alu_op into rsp_* and go to DONE.
REQ-022 Latency: for cmd handshake at edge k, rsp_valid SHALL rise after edge k+W+1 and never earlier.
REQ-023 alu_op/alu_a/alu_b SHALL stay stable from START until return to IDLE.
REQ-024 DONE: rsp_* SHALL hold stable until rsp_ready; on handshake, go to IDLE and increment ops_done.
REQ-025 cmd_ready SHALL be 0 in DONE even when rsp_ready is high; a new command is accepted no earlier than the cycle after the response handshake.
REQ-026 cmd_valid without cmd_ready SHALL be ignored; cmd_* inputs outside the handshake edge SHALL have no effect.
REQ-027 rsp_y_ext SHALL be captured for all opcodes; it is meaningful only for 111; rsp_ovf is meaningful only for 000/001.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, alu_start 0, rsp_valid 0, busy 0, cmd_ready 1 only after rst_n is released.
REQ-029 While rst_n is low, cmd_ready SHALL be 0; reset SHALL clear alu_op/a/b, rsp_*, counter, and ops_done to 0.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the operation with no response and no ops_done increment.

Verification (N=4, driver connected to team alu, a=5, b=13)
REQ-031 add -> rsp_y=0010, rsp_ovf=1; rsp_valid rises after edge k+5; ops_done=1 after rsp handshake.
REQ-032 sub -> rsp_y=1000 (signed -8); mul -> rsp_y_ext=0100, rsp_y=0001 (65).
REQ-033 shl shamt=2 -> rsp_y=0100 after edge k+3; shr shamt=2 -> rsp_y=0001; shamt=0 -> behaves as 1; shamt=7 -> behaves as 4.
REQ-034 rsp_ready held low 10 cycles in DONE -> rsp_* stable, cmd_ready 0, cmd_valid ignored; then rsp_ready=1 -> IDLE next cycle.
REQ-035 rst_n pulsed low during RUN of mul -> rsp_valid never asserts for that op, busy 0 immediately, next command completes correctly.
REQ-036 Back-to-back 256 commands with rsp_ready=1 -> exactly one alu_start per command, ops_done wraps to 0.

Source files
------------

// File: rtl/alu_driver_if.sv
// Bundled command, ALU-side and response signals of the ALU driver.
// The slave modport is the driver's view; master is the environment's view.
interface alu_driver_if #(
  parameter int N  = 4,
  parameter int SW = $clog2(N) + 1
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [N-1:0]  cmd_a;
  logic [N-1:0]  cmd_b;
  logic [SW-1:0] cmd_shamt;

  logic          alu_start;
  logic [2:0]    alu_op;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [N-1:0]  alu_y;
  logic [N-1:0]  alu_y_ext;
  logic          alu_ovf;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [2:0]    rsp_op;
  logic [N-1:0]  rsp_y;
  logic [N-1:0]  rsp_y_ext;
  logic          rsp_ovf;

  logic          busy;
  logic [7:0]    ops_done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shamt,
    input  alu_y, alu_y_ext, alu_ovf,
    input  rsp_ready,
    output cmd_ready, alu_start, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_op, rsp_y, rsp_y_ext, rsp_ovf,
    output busy, ops_done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shamt,
    output alu_y, alu_y_ext, alu_ovf,
    output rsp_ready,
    input  cmd_ready, alu_start, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_op, rsp_y, rsp_y_ext, rsp_ovf,
    input  busy, ops_done
  );
endinterface

// File: rtl/alu_driver.sv
// Sequences one command at a time through a multi-cycle ALU: latch operands,
// pulse start, wait W cycles, capture the result and hold it until consumed.
module alu_driver #(
  parameter int N  = 4,
  parameter int SW = $clog2(N) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_driver_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_wait;
  logic [SW-1:0] w_shamt;
  logic [2:0]    r_aluOp;
  logic [N-1:0]  r_aluA;
  logic [N-1:0]  r_aluB;
  logic [2:0]    r_rspOp;
  logic [N-1:0]  r_rspY;
  logic [N-1:0]  r_rspYExt;
  logic          r_rspOvf;
  logic [7:0]    r_opsDone;
  logic          w_cmdFire;
  logic          w_rspFire;
  logic          w_lastRun;
  logic          w_isShift;

  assign w_shamt   = bus.cmd_shamt;
  assign w_isShift = (bus.cmd_op == 3'b101) || (bus.cmd_op == 3'b110);
  assign w_cmdFire = (r_state == IDLE) && bus.cmd_valid;
  assign w_rspFire = (r_state == DONE) && bus.rsp_ready;
  assign w_lastRun = (r_state == RUN) && (r_count == CW'(1));

  // Shifts run one ALU cycle per bit, so their wait is the clamped shift amount.
  always_comb begin
    w_wait = CW'(N);
    if (w_isShift) begin
      if (w_shamt == '0) begin
        w_wait = CW'(1);
      end else if (int'(w_shamt) < N) begin
        w_wait = CW'(w_shamt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // cmd_ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    w_next        = r_state;
    bus.cmd_ready = 1'b0;
    bus.alu_start = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      IDLE: begin
        bus.busy      = 1'b0;
        bus.cmd_ready = rst_n;
        if (bus.cmd_valid) begin
          w_next = START;
        end
      end
      START: begin
        bus.alu_start = 1'b1;
        w_next        = RUN;
      end
      RUN: begin
        if (r_count == CW'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_aluOp   <= '0;
      r_aluA    <= '0;
      r_aluB    <= '0;
      r_rspOp   <= '0;
      r_rspY    <= '0;
      r_rspYExt <= '0;
      r_rspOvf  <= 1'b0;
      r_opsDone <= '0;
    end else begin
      if (w_cmdFire) begin
        r_aluOp <= bus.cmd_op;
        r_aluA  <= bus.cmd_a;
        r_aluB  <= bus.cmd_b;
        r_count <= w_wait;
      end else if (r_state == RUN) begin
        r_count <= r_count - CW'(1);
        if (w_lastRun) begin
          r_rspOp   <= r_aluOp;
          r_rspY    <= bus.alu_y;
          r_rspYExt <= bus.alu_y_ext;
          r_rspOvf  <= bus.alu_ovf;
        end
      end
      if (w_rspFire) begin
        r_opsDone <= r_opsDone + 8'd1;
      end
    end
  end

  assign bus.alu_op    = r_aluOp;
  assign bus.alu_a     = r_aluA;
  assign bus.alu_b     = r_aluB;
  assign bus.rsp_op    = r_rspOp;
  assign bus.rsp_y     = r_rspY;
  assign bus.rsp_y_ext = r_rspYExt;
  assign bus.rsp_ovf   = r_rspOvf;
  assign bus.ops_done  = r_opsDone;
endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver with a behavioural multi-cycle ALU (shifts one bit per
// cycle) and a scoreboard queue of expected responses.
module tb_alu_driver;
  localparam int N  = 4;
  localparam int SW = $clog2(N) + 1;
  localparam int NV = 17;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] shamt;
    logic [3:0] expY;
    logic [3:0] expExt;
    logic       expOvf;
    logic [3:0] expW;
  } vec_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic [3:0] ext;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_driver_if #(.N(N), .SW(SW)) bus();
  alu_driver #(.N(N), .SW(SW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  int   startCount = 0;
  int   expStarts = 0;
  int   expOps = 0;
  logic watchDiscard = 1'b0;
  logic badRsp = 1'b0;
  exp_t sbQ[$];
  vec_t vecs [NV];

  logic [3:0] acc;
  logic [4:0] sum;
  logic [7:0] prod;

  always @(posedge clk) begin
    if (bus.alu_start) begin
      acc <= (bus.alu_op == 3'b101) ? (bus.alu_a << 1) : (bus.alu_a >> 1);
    end else begin
      acc <= (bus.alu_op == 3'b101) ? (acc << 1) : (acc >> 1);
    end
  end

  always_comb begin
    sum           = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    prod          = {4'b0, bus.alu_a} * {4'b0, bus.alu_b};
    bus.alu_y     = 4'd0;
    bus.alu_y_ext = 4'd0;
    bus.alu_ovf   = 1'b0;
    case (bus.alu_op)
      3'b000: begin bus.alu_y = sum[3:0]; bus.alu_ovf = sum[4]; end
      3'b001: begin bus.alu_y = bus.alu_a - bus.alu_b; bus.alu_ovf = (bus.alu_a < bus.alu_b); end
      3'b010: bus.alu_y = bus.alu_a & bus.alu_b;
      3'b011: bus.alu_y = bus.alu_a | bus.alu_b;
      3'b100: bus.alu_y = ~bus.alu_a;
      3'b101: bus.alu_y = acc;
      3'b110: bus.alu_y = acc;
      default: begin bus.alu_y = prod[3:0]; bus.alu_y_ext = prod[7:4]; end
    endcase
  end

  always @(negedge clk) begin
    if (bus.alu_start) startCount++;
    if (watchDiscard && bus.rsp_valid) badRsp = 1'b1;
  end

  task automatic checkOutput(input string what, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int   guard;
    exp_t e;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    bus.cmd_shamt = v.shamt;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cmd_accept", int'(bus.cmd_ready), 1);
    e.op = v.op; e.a = v.a; e.b = v.b; e.y = v.expY; e.ext = v.expExt; e.ovf = v.expOvf;
    sbQ.push_back(e);
    expStarts++;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_a     = 4'($urandom);
    bus.cmd_b     = 4'($urandom);
    bus.cmd_shamt = 3'($urandom);
  endtask

  task automatic waitResponse(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 64) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic checkResponse();
    exp_t e;
    checkOutput("sb_pending", sbQ.size(), 1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("rsp_valid", int'(bus.rsp_valid), 1);
      checkOutput("rsp_op", int'(bus.rsp_op), int'(e.op));
      checkOutput("rsp_y", int'(bus.rsp_y), int'(e.y));
      if (e.op == 3'b111) checkOutput("rsp_y_ext", int'(bus.rsp_y_ext), int'(e.ext));
      if (e.op == 3'b000 || e.op == 3'b001) checkOutput("rsp_ovf", int'(bus.rsp_ovf), int'(e.ovf));
      checkOutput("alu_op_stable", int'(bus.alu_op), int'(e.op));
      checkOutput("alu_a_stable", int'(bus.alu_a), int'(e.a));
      checkOutput("alu_b_stable", int'(bus.alu_b), int'(e.b));
    end
  endtask

  task automatic finishResponse();
    @(posedge clk);
    @(negedge clk);
    expOps = (expOps + 1) % 256;
    checkOutput("ops_done", int'(bus.ops_done), expOps);
    checkOutput("cmd_ready_after_rsp", int'(bus.cmd_ready), 1);
    checkOutput("rsp_valid_after_rsp", int'(bus.rsp_valid), 0);
    checkOutput("alu_start_count", startCount, expStarts);
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    applyStimulus(v);
    waitResponse(lat);
    checkOutput("latency", lat, int'(v.expW) + 1);
    checkResponse();
    finishResponse();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    //          op      a      b      sh     y      ext    ovf   W
    vecs[0]  = '{3'b000, 4'd5,  4'd13, 3'd0, 4'd2,  4'd0,  1'b1, 4'd4};
    vecs[1]  = '{3'b001, 4'd5,  4'd13, 3'd0, 4'd8,  4'd0,  1'b1, 4'd4};
    vecs[2]  = '{3'b010, 4'd5,  4'd13, 3'd0, 4'd5,  4'd0,  1'b0, 4'd4};
    vecs[3]  = '{3'b011, 4'd5,  4'd13, 3'd0, 4'd13, 4'd0,  1'b0, 4'd4};
    vecs[4]  = '{3'b100, 4'd5,  4'd13, 3'd0, 4'd10, 4'd0,  1'b0, 4'd4};
    vecs[5]  = '{3'b111, 4'd5,  4'd13, 3'd0, 4'd1,  4'd4,  1'b0, 4'd4};
    vecs[6]  = '{3'b101, 4'd5,  4'd13, 3'd2, 4'd4,  4'd0,  1'b0, 4'd2};
    vecs[7]  = '{3'b110, 4'd5,  4'd13, 3'd2, 4'd1,  4'd0,  1'b0, 4'd2};
    vecs[8]  = '{3'b101, 4'd5,  4'd13, 3'd0, 4'd10, 4'd0,  1'b0, 4'd1};
    vecs[9]  = '{3'b101, 4'd5,  4'd13, 3'd7, 4'd0,  4'd0,  1'b0, 4'd4};
    vecs[10] = '{3'b110, 4'd5,  4'd13, 3'd0, 4'd2,  4'd0,  1'b0, 4'd1};
    vecs[11] = '{3'b110, 4'd5,  4'd13, 3'd7, 4'd0,  4'd0,  1'b0, 4'd4};
    vecs[12] = '{3'b110, 4'd13, 4'd0,  3'd3, 4'd1,  4'd0,  1'b0, 4'd3};
    vecs[13] = '{3'b000, 4'd3,  4'd4,  3'd0, 4'd7,  4'd0,  1'b0, 4'd4};
    vecs[14] = '{3'b111, 4'd15, 4'd15, 3'd0, 4'd1,  4'd14, 1'b0, 4'd4};
    vecs[15] = '{3'b001, 4'd13, 4'd5,  3'd0, 4'd8,  4'd0,  1'b0, 4'd4};
    vecs[16] = '{3'b101, 4'd3,  4'd9,  3'd1, 4'd6,  4'd0,  1'b0, 4'd1};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 4'd0;
    bus.cmd_b     = 4'd0;
    bus.cmd_shamt = 3'd0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_cmd_ready", int'(bus.cmd_ready), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("reset_alu_start", int'(bus.alu_start), 0);
    checkOutput("reset_ops_done", int'(bus.ops_done), 0);
    checkOutput("reset_rsp_y", int'(bus.rsp_y), 0);
    checkOutput("reset_alu_a", int'(bus.alu_a), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_cmd_ready", int'(bus.cmd_ready), 1);
    checkOutput("idle_busy", int'(bus.busy), 0);

    $display("[TB] table vectors");
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NV; i++) runVector(vecs[i]);

    // Response held off: outputs frozen, new commands refused.
    $display("[TB] response backpressure");
    bus.rsp_ready = 1'b0;
    applyStimulus(vecs[5]);
    waitResponse(lat);
    checkOutput("hold_latency", lat, 5);
    checkResponse();
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'b000;
      bus.cmd_a     = 4'($urandom);
      bus.cmd_b     = 4'($urandom);
      @(negedge clk);
      checkOutput("hold_rsp_valid", int'(bus.rsp_valid), 1);
      checkOutput("hold_cmd_ready", int'(bus.cmd_ready), 0);
      checkOutput("hold_busy", int'(bus.busy), 1);
      checkOutput("hold_rsp_y", int'(bus.rsp_y), 1);
      checkOutput("hold_rsp_y_ext", int'(bus.rsp_y_ext), 4);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    finishResponse();

    // Reset in the middle of a multiply discards it.
    $display("[TB] reset during run");
    applyStimulus(vecs[5]);
    @(negedge clk);
    @(negedge clk);
    checkOutput("run_busy", int'(bus.busy), 1);
    watchDiscard = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", int'(bus.busy), 0);
    checkOutput("midreset_rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("midreset_cmd_ready", int'(bus.cmd_ready), 0);
    checkOutput("midreset_ops_done", int'(bus.ops_done), 0);
    sbQ.delete();
    expOps = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    watchDiscard = 1'b0;
    checkOutput("discard_no_rsp", int'(badRsp), 0);
    checkOutput("discard_ops_done", int'(bus.ops_done), 0);
    runVector(vecs[5]);

    $display("[TB] 256 back-to-back commands");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expOps = 0;
    for (int i = 0; i < 256; i++) runVector(vecs[i % NV]);
    checkOutput("ops_done_wrap", int'(bus.ops_done), 0);
    checkOutput("total_starts", startCount, expStarts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
